// File: rtl/grs_round_ctrl.sv
// Groestl-512 round sequencer: interleaves P and Q permutations
// through one shared pipelined round datapath.
module grs_round_ctrl #(
  parameter int NR     = 14,
  parameter int DP_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] h,
  input  logic [1023:0] m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] out,
  output logic          dp_valid,
  output logic          dp_sel_q,
  output logic [3:0]    dp_round,
  output logic [1023:0] dp_in,
  input  logic [1023:0] dp_out
);

  localparam int PW = $clog2(DP_LAT);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = PW'(DP_LAT - 1);
  localparam logic [PW-1:0] PH_PFIN = PW'(DP_LAT - 2);
  localparam logic [3:0]    RND_LAST = 4'(NR - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ph, ph_nxt;
  logic [3:0]    rnd, rnd_nxt;
  logic [1023:0] h_reg, p_seed, q_seed, p_fin;
  logic [1023:0] hold_in;
  logic          hold_sel;
  logic [3:0]    hold_rnd;
  logic          accept, cap_p, cap_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    rnd_nxt   = rnd;
    accept    = 1'b0;
    cap_p     = 1'b0;
    cap_out   = 1'b0;
    dp_valid  = 1'b0;
    dp_sel_q  = hold_sel;
    dp_round  = hold_rnd;
    dp_in     = hold_in;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
          ph_nxt    = '0;
          rnd_nxt   = '0;
        end
      end
      RUN: begin
        if (ph == PH_LAST) begin
          ph_nxt  = '0;
          rnd_nxt = rnd + 4'd1;
        end else begin
          ph_nxt = ph + PH_ONE;
        end
        // slot 0 issues P, slot 1 issues Q, later slots idle
        if (ph == '0 || ph == PH_ONE) begin
          dp_valid = 1'b1;
          dp_sel_q = ph[0];
          dp_round = rnd;
          if (rnd == 4'd0)
            dp_in = ph[0] ? q_seed : p_seed;
          else
            dp_in = dp_out;
        end
        if (ph == PH_ONE && rnd == RND_LAST) begin
          state_nxt = DRAIN;
          ph_nxt    = '0;
        end
      end
      DRAIN: begin
        ph_nxt = ph + PH_ONE;
        if (ph == PH_PFIN) cap_p = 1'b1;
        if (ph == PH_LAST) begin
          cap_out   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ph       <= '0;
      rnd      <= '0;
      h_reg    <= '0;
      p_seed   <= '0;
      q_seed   <= '0;
      p_fin    <= '0;
      out      <= '0;
      hold_in  <= '0;
      hold_sel <= 1'b0;
      hold_rnd <= '0;
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
      rnd   <= rnd_nxt;
      if (accept) begin
        h_reg  <= h;
        p_seed <= h ^ m;
        q_seed <= m;
      end
      if (dp_valid) begin
        hold_in  <= dp_in;
        hold_sel <= dp_sel_q;
        hold_rnd <= dp_round;
      end
      if (cap_p)   p_fin <= dp_out;
      if (cap_out) out   <= p_fin ^ dp_out ^ h_reg;
    end
  end

endmodule

// File: tb/tb_grs_round_ctrl.sv
// Bench for grs_round_ctrl: two instances (DP_LAT 2 and 4), each with
// an add-one/add-two datapath model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_grs_round_ctrl;

  localparam int NR = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input int l, input string name,
                     input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h",
               l, name, act[63:0], exp[63:0]);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : 4;
    localparam int LATENCY = 3 + NR * LAT;

    logic          reset, in_valid, in_ready, out_valid, out_ready;
    logic          dp_valid, dp_sel_q;
    logic [3:0]    dp_round;
    logic [1023:0] h, m, out, dp_in, dp_out;
    logic [1023:0] pipe [LAT];
    logic [1023:0] expq [$];
    logic [1023:0] prev_out;
    int cyc = 0;
    int acc = 0;
    int pulses = 0;
    int perr = 0;
    bit active = 0;
    bit prev_ov = 0;
    bit done = 0;

    grs_round_ctrl #(.NR(NR), .DP_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .h(h), .m(m),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .dp_valid(dp_valid), .dp_sel_q(dp_sel_q), .dp_round(dp_round),
      .dp_in(dp_in), .dp_out(dp_out)
    );

    always @(posedge clk) begin
      pipe[0] <= dp_valid ? dp_in + (dp_sel_q ? 1024'd2 : 1024'd1) : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      cyc <= cyc + 1;
    end
    assign dp_out = pipe[LAT-1];

    // monitor: tracks issue pattern per job, checks result on out_valid
    initial forever begin
      int j, p;
      @(negedge clk);
      if (reset) begin
        active  = 0;
        prev_ov = 0;
      end else begin
        if (in_valid && in_ready) begin
          active = 1;
          acc    = cyc;
          pulses = 0;
          perr   = 0;
        end else if (active && !out_valid) begin
          j = cyc - acc;
          if (j >= 1 && j <= NR * LAT) begin
            p = (j - 1) % LAT;
            if (dp_valid != (p < 2)) perr++;
            if (p < 2) begin
              pulses++;
              if (dp_sel_q != (p == 1) || dp_round != 4'((j - 1) / LAT))
                perr++;
            end
          end else if (dp_valid) begin
            perr++;
          end
        end
        if (out_valid && !prev_ov) begin
          if (expq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL lane%0d unexpected_out: got 0x%0h expected none",
                     g, out[63:0]);
          end else begin
            chk(g, "result", out, expq.pop_front());
          end
          chk(g, "latency", cyc - acc, LATENCY);
          chk(g, "dp_pulses", pulses, 2 * NR);
          chk(g, "dp_pattern_errs", perr, 0);
          active = 0;
        end else if (out_valid && prev_ov) begin
          chk(g, "out_hold", out, prev_out);
        end
        prev_ov  = out_valid;
        prev_out = out;
      end
    end

    task automatic job(input logic [1023:0] hv, input logic [1023:0] mv,
                       input logic [1023:0] ev, input int hold,
                       input bit scramble);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      h = hv;
      m = mv;
      expq.push_back(ev);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk(g, "in_ready_run", in_ready, 0);
      n = 0;
      while (!out_valid && n < 200) begin
        if (scramble) begin
          h = {32{$urandom}};
          m = {32{$urandom}};
        end
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) begin
        checks++;
        fails++;
        $display("FAIL lane%0d out_valid_timeout: got 0 expected 1", g);
        expq.delete();
        reset = 1'b1;
        #1 reset = 1'b0;
        return;
      end
      in_valid = (hold > 0);
      h = '1;
      m = '1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk(g, "in_ready_busy", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk(g, "in_ready_after", in_ready, 1);
      chk(g, "out_valid_drop", out_valid, 0);
    endtask

    task automatic abort_job();
      @(posedge clk); #1;
      in_valid = 1'b1;
      h = '0;
      m = '0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7 * LAT) @(posedge clk);
      #1;
      chk(g, "pre_abort_valid", dp_valid, 1);
      chk(g, "pre_abort_round", dp_round, 7);
      reset = 1'b1;
      #1;
      chk(g, "abort_in_ready", in_ready, 1);
      chk(g, "abort_out_valid", out_valid, 0);
      chk(g, "abort_out", out, 0);
      chk(g, "abort_dp_valid", dp_valid, 0);
      chk(g, "abort_dp_sel_q", dp_sel_q, 0);
      chk(g, "abort_dp_round", dp_round, 0);
      chk(g, "abort_dp_in", dp_in, 0);
      @(posedge clk); #1;
      reset = 1'b0;
    endtask

    initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      h = '0;
      m = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(g, "rst_in_ready", in_ready, 1);
      chk(g, "rst_out_valid", out_valid, 0);
      chk(g, "rst_out", out, 0);
      chk(g, "rst_dp_valid", dp_valid, 0);
      chk(g, "rst_dp_in", dp_in, 0);
      reset = 1'b0;
      job(1024'h0, 1024'h0, 1024'h12, 0, 0);
      job(1024'h1, 1024'h0, 1024'h12, 0, 0);
      job(1024'hFF, 1024'h01, 1024'h1EE, 10, 0);
      job({1024{1'b1}}, 1024'h0, {{1016{1'b1}}, 8'hEE}, 0, 0);
      abort_job();
      job(1024'h0, 1024'h0, 1024'h12, 0, 0);
      job(1024'hA5, 1024'h3C, 1024'h5A, 0, 1);
      repeat (3) @(posedge clk);
      chk(g, "queue_empty", expq.size(), 0);
      done = 1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(lane[0].done && lane[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(lane[0].done && lane[1].done)) begin
      checks++;
      fails++;
      $display("FAIL global_timeout: got %0d cycles expected completion", n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/grs_round_ctrl.md
# grs_round_ctrl

Iterative round sequencer for the Groestl-512 compression function. It time-shares one pipelined 1024-bit round datapath (AddRoundConstant, SubBytes, ShiftBytes and the registered mix_bytes stage) between the P and Q permutations, interleaving them slot by slot. It computes out = P(h ^ m) ^ Q(m) ^ h. It sits between the message/chaining-value feeder and the output transform in the myr_grs hashing core.

## Interface

Parameters:
- NR, 14: rounds per permutation.
- DP_LAT, 2: datapath latency in cycles from issue to result. Legal range is DP_LAT >= 2.

Ports:
- clk, input, 1: single clock, all logic on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: job offered on h/m.
- in_ready, output, 1: controller can accept a job.
- h, input, 1024: chaining value.
- m, input, 1024: message block.
- out_valid, output, 1: out holds a completed result.
- out_ready, input, 1: consumer accepts out.
- out, output, 1024: P(h^m) ^ Q(m) ^ h.
- dp_valid, output, 1: issue slot active this cycle.
- dp_sel_q, output, 1: 0 = P constants, 1 = Q constants.
- dp_round, output, 4: round index 0..NR-1.
- dp_in, output, 1024: datapath state input.
- dp_out, input, 1024: datapath result. The result for an issue in cycle c is valid in cycle c+DP_LAT.

## Operation

State machine:
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register h into h_reg and h^m into p_seed, and m into q_seed.
  - Clear round counter rnd and phase counter ph. Go to RUN.
- RUN:
  - ph counts 0..DP_LAT-1 and wraps. rnd increments when ph wraps.
  - ph==0 is the P slot: dp_valid=1, dp_sel_q=0, dp_round=rnd. dp_in = p_seed if rnd==0, else dp_out.
  - ph==1 is the Q slot: dp_valid=1, dp_sel_q=1, dp_round=rnd. dp_in = q_seed if rnd==0, else dp_out.
  - ph>=2 is idle: dp_valid=0. dp_in, dp_sel_q and dp_round hold their last values.
  - After the Q slot of round NR-1, go to DRAIN.
- DRAIN:
  - Capture dp_out into p_fin in the cycle the final P result returns.
  - In the cycle the final Q result returns, register out = p_fin ^ dp_out ^ h_reg. Go to DONE.
- DONE:
  - out_valid=1, and out is held stable.
  - On out_ready, go to IDLE. out_valid drops the next cycle.

Rules:
- dp_in feeds back dp_out combinationally for rounds > 0. The controller adds no register on the feedback path.
- in_ready is a pure decode of state==IDLE. No new job is accepted in the cycle that out is consumed.
- Inputs h and m are sampled only on the accept edge. Later changes on h/m have no effect.
- Reset in any state returns to IDLE asynchronously. The in-flight job is discarded, and datapath results arriving afterwards are ignored.

Reset values:
- state=IDLE, in_ready=1.
- out_valid=0, out=0.
- dp_valid=0, dp_sel_q=0, dp_round=0, dp_in=0.
- rnd=0, ph=0.

## Timing

Let A be the accept edge.
- P round r issues in cycle A+1+r*DP_LAT.
- Q round r issues in cycle A+2+r*DP_LAT.
- The final P result appears on dp_out in cycle A+1+NR*DP_LAT.
- The final Q result appears on dp_out in cycle A+2+NR*DP_LAT.
- out_valid rises in cycle A+3+NR*DP_LAT. With the defaults that is 31 cycles after accept.
- Throughput is one job per NR*DP_LAT+3 cycles, plus the out_ready wait, plus 1 cycle back in IDLE.
- dp_valid duty cycle is 2/DP_LAT during RUN.
- out_valid and out stay stable while out_ready=0.

## Test plan

Each scenario uses a bench datapath model with latency DP_LAT: dp_out = dp_in + 1 for P issues and dp_in + 2 for Q issues (1024-bit add).

1. Reset, then accept h=0, m=0 with defaults:
   - out_valid rises exactly 31 cycles after accept.
   - out = 0x12 (14 ^ 28).
   - Exactly 28 dp_valid pulses occur, alternating P and Q.
   - dp_round runs 0..13.
2. h=1, m=0:
   - out = 0x12.
   - h=0xFF, m=0x01: out = (0xFE+14) ^ (0x01+28) ^ 0xFF = 0x10C ^ 0x1D ^ 0xFF = 0x1EE.
3. Hold out_ready=0 for 10 cycles after out_valid:
   - out stays constant.
   - in_ready stays 0, and a second in_valid is not accepted.
   - One cycle after out_ready, in_ready=1.
4. DP_LAT=4:
   - dp_valid pattern is 1,1,0,0 repeated.
   - out_valid 59 cycles after accept.
   - Same out values as scenario 1.
5. Assert reset mid-RUN at round 7:
   - All outputs return to their reset values immediately.
   - A fresh job afterwards produces the correct 0x12 result, unaffected by stale dp_out.
6. Change h/m every cycle after accept: the result matches the values sampled on the accept edge.
